// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Forwarding and load-use hazard unit that sits beside the decode stage.
// It keeps a shift register of in-flight register writers, one entry per
// downstream stage (entry index 0 holds stage 1, the youngest), and compares
// every source operand of the decode instruction against it.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset; invalidates all entries
//   issue_valid     decode holds a valid instruction
//   issue_rd        destination register of the decode instruction
//   issue_reg_write decode instruction writes issue_rd
//   issue_mem_read  decode instruction is a load
//   src_addr        packed source addresses, operand k at [k*REG_ADDR_W +: REG_ADDR_W]
//   src_used        operand k is actually read
//   flush           squash every in-flight entry at the next edge
//   stall           hold fetch/decode and inject a bubble (load-use hazard)
//   fwd_sel         per operand: 0 = register file, i = result of stage i
//   pending_count   number of valid entries in flight (state only)
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int R0_ZERO    = 0,
    localparam int FSEL_W    = $clog2(FWD_STAGES + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic                          issue_reg_write,
    input  logic                          issue_mem_read,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_used,
    input  logic                          flush,
    output logic                          stall,
    output logic [NUM_SRC*FSEL_W-1:0]     fwd_sel,
    output logic [FSEL_W-1:0]             pending_count
);

    logic                  entValid [FWD_STAGES];
    logic [REG_ADDR_W-1:0] entRd    [FWD_STAGES];
    logic                  entLoad  [FWD_STAGES];

    logic [FSEL_W-1:0]     winSel     [NUM_SRC];
    logic                  winUnready [NUM_SRC];
    logic                  hazard;
    logic                  pushEn;

    // Stalled instructions must not enter the scoreboard: the bubble goes in instead.
    assign pushEn = issue_valid && !hazard && issue_reg_write;

    // Valid bits carry the control state and are the only thing reset/flush touch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FWD_STAGES; i++) entValid[i] <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < FWD_STAGES; i++) entValid[i] <= 1'b0;
        end else begin
            entValid[0] <= pushEn;
            for (int i = 1; i < FWD_STAGES; i++) entValid[i] <= entValid[i-1];
        end
    end

    // Payload shifts freely; it is only ever looked at through its valid bit.
    always_ff @(posedge clk) begin
        entRd[0]   <= issue_rd;
        entLoad[0] <= issue_mem_read;
        for (int i = 1; i < FWD_STAGES; i++) begin
            entRd[i]   <= entRd[i-1];
            entLoad[i] <= entLoad[i-1];
        end
    end

    // Scan oldest to youngest so the youngest match overwrites and wins.
    // The winner's readiness is kept even when unready, so an older ready
    // copy can never mask a young load that is still in flight.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            winSel[k]     = '0;
            winUnready[k] = 1'b0;
            for (int i = FWD_STAGES - 1; i >= 0; i--) begin
                if (src_used[k] && entValid[i] &&
                    entRd[i] == src_addr[k*REG_ADDR_W +: REG_ADDR_W] &&
                    (R0_ZERO == 0 || src_addr[k*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
                    winSel[k]     = FSEL_W'(i + 1);
                    winUnready[k] = entLoad[i] && ((i + 1) <= LOAD_LAT);
                end
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) hazard = hazard | winUnready[k];
        hazard = hazard && issue_valid;
    end

    always_comb begin
        fwd_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (issue_valid && !hazard) fwd_sel[k*FSEL_W +: FSEL_W] = winSel[k];
        end
    end

    assign stall = hazard;

    always_comb begin
        pending_count = '0;
        for (int i = 0; i < FWD_STAGES; i++) begin
            if (entValid[i]) pending_count = pending_count + FSEL_W'(1);
        end
    end

endmodule
